// File: rtl/fp_add_pkg.sv
// Shared widths, limits, state encoding and control encodings for the FP adder controller.
// Latency: n/a (constants only); backpressure: n/a.
package fp_add_pkg;

    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int ALIGN_SAT = FRAC_W + 1;
    localparam int MAX_NORM  = 24;
    localparam int CNT_W     = $clog2(MAX_NORM + 1);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    localparam logic NORM_LEFT  = 1'b1;
    localparam logic NORM_RIGHT = 1'b0;
    localparam logic EXP_INC    = 1'b0;
    localparam logic EXP_DEC    = 1'b1;

endpackage

// File: rtl/fp_align_sat.sv
// Signed exponent difference to saturated alignment shift and smaller-operand select.
// Latency: combinational; backpressure: none.
module fp_align_sat
    import fp_add_pkg::*;
(
    input  logic [EXP_W-1:0] exp_diff,
    output logic             sel_small,
    output logic [EXP_W-1:0] shamt
);

    logic [EXP_W:0] ext;
    logic [EXP_W:0] mag;

    // One extra bit so that the most negative difference still has a positive magnitude.
    always_comb begin
        ext       = {exp_diff[EXP_W-1], exp_diff};
        sel_small = exp_diff[EXP_W-1];
        mag       = sel_small ? -ext : ext;
        if (mag > (EXP_W+1)'(ALIGN_SAT))
            shamt = EXP_W'(ALIGN_SAT);
        else
            shamt = mag[EXP_W-1:0];
    end

endmodule

// File: rtl/fp_add_control.sv
// Sequencer for the effective-add FP datapath: compare, align, add, normalise loop.
// Latency: done 5 cycles after start plus one per normalise step; start is ignored while busy or in DONE.
module fp_add_control
    import fp_add_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [EXP_W-1:0] exp_diff,
    input  logic             sum_carry,
    input  logic             sum_msb,
    input  logic             sum_zero,
    input  logic             exp_max,
    input  logic             exp_min,
    output logic             sel_small,
    output logic [EXP_W-1:0] align_shamt,
    output logic             ld_align,
    output logic             ld_sum,
    output logic             norm_dir,
    output logic [EXP_W-1:0] norm_shamt,
    output logic             exp_step,
    output logic             ld_norm,
    output logic             busy,
    output logic             done,
    output logic             flag_ovf,
    output logic             flag_unf,
    output logic             flag_zero
);

    state_t           state;
    logic [CNT_W-1:0] norm_cnt;
    logic             sel_small_c;
    logic [EXP_W-1:0] shamt_c;

    logic fin_zero, fin_ovf, fin_unf, fin_ok;
    logic step_right, step_left;

    fp_align_sat u_align (
        .exp_diff  (exp_diff),
        .sel_small (sel_small_c),
        .shamt     (shamt_c)
    );

    // Flags seen here come from registers loaded on an earlier cycle, never from this cycle's load.
    always_comb begin
        fin_zero   = 1'b0;
        fin_ovf    = 1'b0;
        fin_unf    = 1'b0;
        fin_ok     = 1'b0;
        step_right = 1'b0;
        step_left  = 1'b0;
        if (state == NORM) begin
            if (sum_zero)
                fin_zero = 1'b1;
            else if (sum_carry && exp_max)
                fin_ovf = 1'b1;
            else if (sum_carry)
                step_right = 1'b1;
            else if (!sum_msb && (exp_min || norm_cnt == CNT_W'(MAX_NORM)))
                fin_unf = 1'b1;
            else if (!sum_msb)
                step_left = 1'b1;
            else
                fin_ok = 1'b1;
        end
    end

    always_comb begin
        ld_norm    = step_right | step_left;
        norm_dir   = step_left ? NORM_LEFT : NORM_RIGHT;
        exp_step   = step_left ? EXP_DEC : EXP_INC;
        norm_shamt = ld_norm ? EXP_W'(1) : '0;
    end

    assign ld_align = (state == ALIGN);
    assign ld_sum   = (state == ADD);
    assign busy     = (state == COMPARE) || (state == ALIGN) || (state == ADD) || (state == NORM);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            norm_cnt    <= '0;
            sel_small   <= 1'b0;
            align_shamt <= '0;
            flag_ovf    <= 1'b0;
            flag_unf    <= 1'b0;
            flag_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        flag_ovf  <= 1'b0;
                        flag_unf  <= 1'b0;
                        flag_zero <= 1'b0;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    sel_small   <= sel_small_c;
                    align_shamt <= shamt_c;
                    state       <= ALIGN;
                end
                ALIGN: state <= ADD;
                ADD: begin
                    norm_cnt <= '0;
                    state    <= NORM;
                end
                NORM: begin
                    if (step_left)
                        norm_cnt <= norm_cnt + 1'b1;
                    if (fin_zero)
                        flag_zero <= 1'b1;
                    if (fin_ovf)
                        flag_ovf <= 1'b1;
                    if (fin_unf)
                        flag_unf <= 1'b1;
                    if (fin_zero || fin_ovf || fin_unf || fin_ok)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_control.sv
// Directed bench for fp_add_control with a per-run expected timeline built from the rule list.
module tb_fp_add_control;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] exp_diff;
    logic       sum_carry, sum_msb, sum_zero, exp_max, exp_min;
    logic       sel_small, ld_align, ld_sum, norm_dir, exp_step, ld_norm, busy, done;
    logic [7:0] align_shamt, norm_shamt;
    logic       flag_ovf, flag_unf, flag_zero;

    fp_add_control dut (
        .clk(clk), .reset(reset), .start(start), .exp_diff(exp_diff),
        .sum_carry(sum_carry), .sum_msb(sum_msb), .sum_zero(sum_zero),
        .exp_max(exp_max), .exp_min(exp_min),
        .sel_small(sel_small), .align_shamt(align_shamt), .ld_align(ld_align), .ld_sum(ld_sum),
        .norm_dir(norm_dir), .norm_shamt(norm_shamt), .exp_step(exp_step), .ld_norm(ld_norm),
        .busy(busy), .done(done), .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_zero(flag_zero)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Per-NORM-cycle datapath flags, packed {zero, carry, msb, emax, emin}.
    bit [4:0] nv [0:63];
    int       nlen;

    // Model results: NORM cycle count, step kind per cycle (0 none, 1 right, 2 left), final flags.
    int       m_n;
    int       m_st [0:63];
    bit [2:0] m_fl;
    bit       m_sel;
    bit [7:0] m_sh;
    bit       prev_sel;
    bit [7:0] prev_sh;
    bit [2:0] prev_fl;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    task automatic fill(input int len, input bit [4:0] v);
        for (int i = 0; i < 64; i++) nv[i] = v;
        nlen = len;
    endtask

    task automatic model(input int ed);
        int  cnt;
        bit  fin;
        cnt = 0;
        fin = 1'b0;
        m_n = 0;
        m_fl = 3'b000;
        for (int i = 0; i < 64 && !fin; i++) begin
            bit [4:0] v;
            v = (i < nlen) ? nv[i] : 5'b00100;
            m_n = i + 1;
            m_st[i] = 0;
            if (v[4]) begin m_fl = 3'b001; fin = 1'b1; end
            else if (v[3] && v[1]) begin m_fl = 3'b100; fin = 1'b1; end
            else if (v[3]) m_st[i] = 1;
            else if (!v[2] && (v[0] || cnt == 24)) begin m_fl = 3'b010; fin = 1'b1; end
            else if (!v[2]) begin m_st[i] = 2; cnt++; end
            else fin = 1'b1;
        end
        m_sel = (ed < 0);
        m_sh  = 8'((ed < 0 ? -ed : ed) > 24 ? 24 : (ed < 0 ? -ed : ed));
    endtask

    // Expected {sel, shamt, ld_align, ld_sum, dir, nshamt, step, ld_norm, busy, done, ovf, unf, zero}.
    function automatic logic [31:0] expv(input int k);
        logic s, la, ls, nd, es, ln, b, d;
        logic [7:0] sh, ns;
        logic [2:0] fl;
        s  = (k >= 2) ? m_sel : prev_sel;
        sh = (k >= 2) ? m_sh : prev_sh;
        la = (k == 2);
        ls = (k == 3);
        nd = 0; es = 0; ln = 0; ns = 0;
        if (k >= 4 && k < 4 + m_n && m_st[k-4] != 0) begin
            ln = 1; ns = 8'd1;
            nd = (m_st[k-4] == 2);
            es = (m_st[k-4] == 2);
        end
        b  = (k >= 1) && (k < 4 + m_n);
        d  = (k == 4 + m_n);
        fl = (k == 0) ? prev_fl : ((k < 4 + m_n) ? 3'b000 : m_fl);
        return 32'({s, sh, la, ls, nd, ns, es, ln, b, d, fl});
    endfunction

    function automatic logic [31:0] actv();
        return 32'({sel_small, align_shamt, ld_align, ld_sum, norm_dir, norm_shamt, exp_step,
                    ld_norm, busy, done, flag_ovf, flag_unf, flag_zero});
    endfunction

    task automatic drive(input int k, input int ed, input bit st);
        start    = st;
        exp_diff = 8'(ed);
        {sum_zero, sum_carry, sum_msb, exp_max, exp_min} =
            (k >= 4 && k - 4 < nlen) ? nv[k-4] : 5'b00100;
    endtask

    task automatic run(input string nm, input int ed, input bit hold, input bit lsel, input int lsh,
                       input int ldone, input int lnld, input bit [2:0] lfl);
        int obs_done, nld;
        model(ed);
        obs_done = -1;
        nld = 0;
        for (int k = 0; k < 4 + m_n + 3; k++) begin
            @(posedge clk); #1;
            drive(k, ed, (k == 0) || (hold && k <= 4 + m_n));
            @(negedge clk);
            chk({nm, "_outputs"}, k, actv(), expv(k));
            if (done && obs_done < 0) obs_done = k;
            if (ld_norm) nld++;
            if (k == 2) chk({nm, "_align"}, k, {sel_small, align_shamt}, {lsel, 8'(lsh)});
            if (k == 4 + m_n) chk({nm, "_flags"}, k, {flag_ovf, flag_unf, flag_zero}, lfl);
        end
        start = 1'b0;
        chk({nm, "_done_cycle"}, obs_done, obs_done, ldone);
        chk({nm, "_ld_norm_count"}, obs_done, nld, lnld);
        prev_sel = m_sel;
        prev_sh  = m_sh;
        prev_fl  = m_fl;
    endtask

    task automatic run_reset_mid();
        int ndone;
        fill(64, 5'b00000);
        model(5);
        ndone = 0;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            drive(k, 5, k == 0);
            reset = (k == 5);
            @(negedge clk);
            if (done) ndone++;
            chk("reset_mid_outputs", k, actv(), (k <= 5) ? expv(k) : 32'd0);
        end
        chk("reset_mid_no_done", 10, ndone, 0);
        prev_sel = 1'b0;
        prev_sh  = 8'd0;
        prev_fl  = 3'b000;
    endtask

    initial begin
        reset = 1'b1;
        fill(0, 5'b00100);
        drive(0, 0, 1'b0);
        prev_sel = 1'b0;
        prev_sh  = 8'd0;
        prev_fl  = 3'b000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_state", k, actv(), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        fill(1, 5'b00100);
        run("norm_first", 3, 1'b0, 1'b0, 3, 5, 0, 3'b000);
        run("diff_m30", -30, 1'b0, 1'b1, 24, 5, 0, 3'b000);
        run("diff_m128", -128, 1'b0, 1'b1, 24, 5, 0, 3'b000);
        run("diff_p127", 127, 1'b0, 1'b0, 24, 5, 0, 3'b000);

        fill(2, 5'b00100);
        nv[0] = 5'b01000;
        run("carry_step", 2, 1'b0, 1'b0, 2, 6, 1, 3'b000);
        fill(1, 5'b01010);
        run("carry_ovf_hold_start", -4, 1'b1, 1'b1, 4, 5, 0, 3'b100);
        fill(1, 5'b11000);
        run("zero_carry", 0, 1'b0, 1'b0, 0, 5, 0, 3'b001);

        fill(3, 5'b00000);
        run("left3", 1, 1'b0, 1'b0, 1, 8, 3, 3'b000);
        fill(2, 5'b00000);
        nv[1] = 5'b00001;
        run("left_emin", 24, 1'b0, 1'b0, 24, 6, 1, 3'b010);
        fill(64, 5'b00000);
        run("left_sat", 25, 1'b0, 1'b0, 24, 29, 24, 3'b010);

        run_reset_mid();
        fill(1, 5'b00100);
        run("after_reset", -7, 1'b0, 1'b1, 7, 5, 0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_add_control.md
Name: fp_add_control

Overview:
- FSM that sequences the single-precision floating-point adder datapath: exponent compare, fraction alignment, fraction add, normalisation loop.
- Drives load enables, shift selects and exponent-step controls.
- Consumes status flags from the exponent ALU, fraction adder and result shifter.
- Sits between the issuing unit (start/done handshake) and the datapath. Effective-add only; sign/subtract handling is out of scope.

Parameters:
- EXP_W, 8, exponent width; also the width of exp_diff and both shift amounts.
- FRAC_W, 23, stored fraction width. The alignment saturation limit is FRAC_W+1 = 24.
- MAX_NORM, 24, maximum left-normalise steps before forced underflow.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- exp_diff  in  EXP_W  signed a_exp - b_exp from the exponent ALU.
- sum_carry  in  1  carry out past the hidden bit of the registered sum.
- sum_msb  in  1  hidden-bit position of the registered sum.
- sum_zero  in  1  registered sum fraction is all zero.
- exp_max  in  1  result exponent == 255.
- exp_min  in  1  result exponent == 0.
- sel_small  out  1  operand to align: 0 = b, 1 = a.
- align_shamt  out  EXP_W  alignment right-shift amount.
- ld_align  out  1  load the aligned fraction.
- ld_sum  out  1  load the fraction-adder result.
- norm_dir  out  1  result shifter direction: 1 = left, 0 = right.
- norm_shamt  out  EXP_W  result shift amount.
- exp_step  out  1  exponent ±1 unit select: 0 = +1, 1 = -1.
- ld_norm  out  1  load the shifted result and the stepped exponent.
- busy  out  1  high from COMPARE through NORM.
- done  out  1  one-cycle pulse in DONE.
- flag_ovf, flag_unf, flag_zero  out  1 each  result status; valid from DONE and held until the next accepted start.

Behaviour:
- Reset: state=IDLE, norm counter=0, registered sel_small/align_shamt=0. Every output is 0.
- Reset mid-operation: reset high at an edge returns the block to IDLE. No done pulse is issued and the flags clear.
- States:
  - IDLE: start=1 moves to COMPARE and clears all flags. start=0 stays.
  - COMPARE (1 cycle): register sel_small = (exp_diff<0).
    - Register align_shamt = min(|exp_diff|, 24), computed at EXP_W+1 bits so that -128 gives 128, which saturates to 24.
    - Next state ALIGN.
  - ALIGN (1 cycle): ld_align=1; next state ADD.
  - ADD (1 cycle): ld_sum=1; next state NORM; norm counter cleared.
  - NORM: evaluated every cycle in priority order:
    1. sum_zero=1: flag_zero=1; go to DONE.
    2. sum_carry=1 and exp_max=1: flag_ovf=1; go to DONE.
    3. sum_carry=1 otherwise: norm_dir=0, norm_shamt=1, exp_step=0, ld_norm=1; stay in NORM.
    4. sum_msb=0 and (exp_min=1 or counter==MAX_NORM): flag_unf=1; go to DONE.
    5. sum_msb=0 otherwise: norm_dir=1, norm_shamt=1, exp_step=1, ld_norm=1, counter+1; stay in NORM.
    6. Otherwise (normalised): go to DONE.
  - DONE (1 cycle): done=1, busy=0; next state IDLE unconditionally.
- Output timing:
  - norm_dir/norm_shamt/exp_step/ld_norm are combinational in NORM only and 0 elsewhere.
  - ld_align/ld_sum are state-decoded.
  - sel_small/align_shamt are held from COMPARE until the next start.
- start outside IDLE, including in DONE, is ignored.
- Latency (start accepted at cycle 0):
  - COMPARE=1, ALIGN=2, ADD=3, first NORM=4.
  - With zero normalise steps, done at cycle 5. Each normalise step adds 1 cycle.
- The datapath flags must reflect the registers loaded by ld_sum/ld_norm on the following cycle. The controller never acts on a flag in the same cycle it issues the load.

Decomposition:
- Package fp_add_pkg holds:
  - EXP_W, FRAC_W, ALIGN_SAT (=FRAC_W+1), MAX_NORM;
  - the state enum {IDLE, COMPARE, ALIGN, ADD, NORM, DONE};
  - encodings NORM_LEFT=1/NORM_RIGHT=0 and EXP_INC=0/EXP_DEC=1.
- One sub-module, fp_align_sat: combinational signed-difference to saturated magnitude plus sel_small. It is unit-tested on its own.

Test Plan:
1. exp_diff=+3, first-NORM flags sum_msb=1 with no carry/zero -> sel_small=0, align_shamt=3, single-cycle ld_align at 2 and ld_sum at 3, done at cycle 5, all flags 0.
2. exp_diff=-30, then -128, then +127 -> sel_small=1, align_shamt=24; then sel_small=1, align_shamt=24; then sel_small=0, align_shamt=24.
3. sum_carry=1 in the first NORM cycle, cleared next -> one cycle with ld_norm=1, norm_dir=0, norm_shamt=1, exp_step=0; done at cycle 6. Repeat with exp_max=1 -> no ld_norm, flag_ovf=1, done at 5.
4. sum_msb=0 for 3 NORM cycles -> three ld_norm pulses with norm_dir=1, exp_step=1; done at 8. Repeat with exp_min=1 on the 2nd NORM cycle -> one ld_norm pulse, flag_unf=1, done at 6. Hold sum_msb=0 -> flag_unf after 24 steps.
5. sum_zero=1 together with sum_carry=1 -> flag_zero=1 only, no ld_norm, done at 5.
6. reset asserted in NORM -> IDLE next edge, no done, flags 0. start pulses while busy and in DONE -> ignored, no second run. A new start after IDLE -> flags cleared at COMPARE.
